// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared definitions for the digit-serial subtractor and its adder companion.
//   WIDTH_DEFAULT : default operand width of the adder/subtractor pair
//   state_t       : sequencing states of the subtractor (IDLE, RUN, DONE)
//   deinterleave  : pulls the even (a) or odd (b) bits out of the interleaved
//                   operand bus; also used by the adder testbench
package serial_subtractor_pkg;

   localparam int WIDTH_DEFAULT = 12;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Operand bus layout is bus[2i] = a[i], bus[2i+1] = b[i]; odd selects b.
   function automatic logic [WIDTH_DEFAULT-1:0] deinterleave(
      input logic [2*WIDTH_DEFAULT-1:0] bus,
      input logic                       odd
   );
      logic [WIDTH_DEFAULT-1:0] r;
      r = '0;
      for (int i = 0; i < WIDTH_DEFAULT; i++) begin
         r[i] = bus[2*i + (odd ? 1 : 0)];
      end
      return r;
   endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// sub_digit
// Combinational DIGIT-bit ripple-borrow subtractor computing a_d - b_d - bin.
// Ports:
//   a_d, b_d : DIGIT-bit minuend / subtrahend digit
//   bin      : borrow in from the previous (less significant) digit
//   d        : difference digit
//   bout     : borrow out of the digit's top bit
//   bin_msb  : borrow into the digit's top bit (feeds signed-overflow detection)
module sub_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             bin,
   output logic [DIGIT-1:0] d,
   output logic             bout,
   output logic             bin_msb
);

   logic [DIGIT:0] chain;

   // Classic full-subtractor ripple: a bit borrows when b exceeds a, or when
   // they are equal and a borrow is already coming in from below.
   always_comb begin
      chain    = '0;
      d        = '0;
      chain[0] = bin;
      for (int i = 0; i < DIGIT; i++) begin
         d[i]       = a_d[i] ^ b_d[i] ^ chain[i];
         chain[i+1] = (~a_d[i] & b_d[i]) | (~(a_d[i] ^ b_d[i]) & chain[i]);
      end
   end

   assign bout    = chain[DIGIT];
   assign bin_msb = chain[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Digit-serial (LSB first) unsigned subtractor computing a - b with a
// registered borrow chain; the round-trip partner of the parallel adder.
// Optional feature: define SERIAL_SUBTRACTOR_OVF_EN to add the ovf output
// (signed two's-complement overflow, registered with OUTS).
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : operand bus valid
//   in_ready  : block is idle and can take operands (low while rst is high)
//   INPUTS    : interleaved operands, INPUTS[2i]=a[i], INPUTS[2i+1]=b[i]
//   out_valid : result valid, held until out_ready
//   out_ready : consumer accepts the result
//   OUTS      : {borrow_out, (a-b) mod 2^WIDTH}, kept until the next completion
//   ovf       : (macro only) signed overflow of a - b
// DIGIT must divide WIDTH; the operation takes WIDTH/DIGIT compute cycles.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT,
   parameter int DIGIT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] INPUTS,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH:0]     OUTS
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   ,
   output logic               ovf
`endif
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t           state;
   state_t           next_state;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] res_next;
   logic             borrow;
   logic [CW-1:0]    count;
   logic             last_digit;
   logic [DIGIT-1:0] d;
   logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             bin_msb;
`endif

   // Split the interleaved bus; the shared helper covers the standard width,
   // any other width falls back to an explicit bit loop.
   generate
      if (WIDTH == WIDTH_DEFAULT) begin : g_pkg_split
         assign a_in = deinterleave(INPUTS, 1'b0);
         assign b_in = deinterleave(INPUTS, 1'b1);
      end else begin : g_loop_split
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign a_in[i] = INPUTS[2*i];
            assign b_in[i] = INPUTS[2*i+1];
         end
      end
   endgenerate

   // The operand registers shift right each cycle, so the current digit is
   // always at the bottom and no count-indexed multiplexer is needed.
   sub_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d     (a_reg[DIGIT-1:0]),
      .b_d     (b_reg[DIGIT-1:0]),
      .bin     (borrow),
      .d       (d),
      .bout    (bout),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      .bin_msb (bin_msb)
`else
      .bin_msb ()
`endif
   );

   assign last_digit = (count == CW'(N - 1));

   // New digits enter at the top of the result register; after N shifts the
   // first digit has walked down to bit 0 and the word is in place.
   assign res_next = (res >> DIGIT) | (WIDTH'(d) << (WIDTH - DIGIT));

   // State register: reset wins over everything, including a pending result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and handshake outputs. in_ready is masked by rst so nothing
   // can be accepted on the reset edge; DONE returns to IDLE without
   // re-accepting in the same cycle.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = ~rst;
            if (in_valid) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (last_digit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: capture operands on accept, step one digit per RUN cycle and
   // publish the finished word on the edge that handles the last digit.
   // OUTS is only written at completion, so it survives the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg  <= '0;
         b_reg  <= '0;
         res    <= '0;
         borrow <= 1'b0;
         count  <= '0;
         OUTS   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_reg  <= a_in;
                  b_reg  <= b_in;
                  borrow <= 1'b0;
                  count  <= '0;
               end
            end
            RUN: begin
               a_reg  <= a_reg >> DIGIT;
               b_reg  <= b_reg >> DIGIT;
               res    <= res_next;
               borrow <= bout;
               count  <= count + 1'b1;
               if (last_digit) begin
                  OUTS <= {bout, res_next};
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                  ovf  <= bin_msb ^ bout;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Sequential inverse of the team's 12-bit parallel prefix adder. It computes a − b digit-serially, LSB first, with a registered borrow chain.
- Operands arrive on the same interleaved operand bus the adder consumes: a[i] on INPUTS[2i], b[i] on INPUTS[2i+1].
- The result leaves in the adder's output format: a WIDTH-bit value plus a top bit, here the borrow-out.
- Used as a round-trip checker for the adder (OUTS_adder − b must equal a) and as a low-area benchmark for the synthesis playground.

Parameters:
- WIDTH, 12, operand width in bits.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH. N = WIDTH/DIGIT compute cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bus valid.
- in_ready  output  1  block can accept operands.
- INPUTS  input  2*WIDTH  interleaved operands: INPUTS[2i]=a[i], INPUTS[2i+1]=b[i].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- OUTS  output  WIDTH+1  OUTS[WIDTH-1:0] = (a−b) mod 2^WIDTH; OUTS[WIDTH] = borrow-out (1 iff a<b unsigned).

Behaviour:
- Interface fixed: one clock, clk; reset rst is synchronous and active-high. Nothing is asynchronous.
- Reset values:
  - state=IDLE, out_valid=0, OUTS=0, borrow=0, count=0.
  - in_ready = (state==IDLE) & ~rst, so in_ready is 0 while rst is high.
- FSM states IDLE, RUN, DONE:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge: latch a and b, clear borrow and count, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, the digit at count computes d = a_d − b_d − borrow. The digit's borrow-out is registered. d is shifted into the result register, count increments. On the edge that processes digit N−1: load OUTS = {final borrow, result}, go to DONE.
  - DONE: out_valid=1, OUTS stable. On out_valid&out_ready: go to IDLE. No same-cycle re-accept; in_ready rises the next cycle.
- Latency: accept at edge k → out_valid high after edge k+N (12 cycles at defaults). Throughput is one operation per N+2 cycles at best.
- Operands are captured at accept; later INPUTS changes are ignored. in_valid while not IDLE is ignored and no operand is consumed.
- Backpressure: OUTS and out_valid hold indefinitely while out_ready=0.
- OUTS retains the last result after handshake, until the next completion.
- out_ready while not DONE has no effect.
- rst at any cycle, including mid-RUN or in DONE: next state is IDLE with all registers at reset values. The partial result is discarded and no out_valid pulse occurs.
- Arithmetic: unsigned, modulo 2^WIDTH. The borrow is the complement of carry in a + ~b + 1.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined: adds output ovf (1 bit), registered alongside OUTS.
  - ovf = borrow into MSB XOR borrow out of MSB, i.e. signed two's-complement overflow.
  - Reset value 0; valid with out_valid.
- Undefined: no ovf port and no extra logic. All other behaviour is identical.

Decomposition:
- Shared package serial_subtractor_pkg:
  - WIDTH default constant.
  - state typedef (IDLE, RUN, DONE).
  - Helper function for the even/odd operand deinterleave, reused by the adder testbench.
- One natural sub-module, sub_digit: combinational DIGIT-bit ripple-borrow subtractor (a_d, b_d, bin → d, bout, bin_msb).

Test Plan:
- a=0x005, b=0x003 → after 12 cycles, out_valid=1 and OUTS=13'h0002.
- a=0x000, b=0x001 → OUTS=13'h1FFF (borrow=1). With the macro defined, ovf=0.
- a=0x800, b=0x001 with SERIAL_SUBTRACTOR_OVF_EN → OUTS=13'h07FF, ovf=1. Repeat with a=b=0xFFF → OUTS=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after completion → OUTS/out_valid stable, in_ready=0, and in_valid pulses are ignored. Then out_ready=1 → IDLE, and in_ready=1 one cycle later.
- Assert rst at RUN cycle 6 → next cycle out_valid=0, OUTS=0, in_ready=1 after rst drops. A fresh op a=0x123, b=0x023 then yields OUTS=13'h0100.
- Round trip: 1000 random (a,b) fed through the adder model, then its sum minus b through this block → OUTS[11:0]==a. Borrow equals the adder's carry-out. Repeat with DIGIT=3 and DIGIT=4 (latency 4 and 3 cycles).
